// File: rtl/gprf_pkg.sv
// gprf_pkg: shared definitions for the multi-ported general-purpose register
// file (gprf_mp) and its pending-bit scoreboard (gprf_scoreboard).
// Holds the sweep FSM state encoding and the default geometry constants.
package gprf_pkg;

    // Default geometry: RV-style 32 x 32-bit register file.
    localparam int GPRF_XLEN_DEF = 32;
    localparam int GPRF_NREG_DEF = 32;

    // Clear-sweep controller states.
    typedef enum logic [0:0] {
        GPRF_IDLE = 1'b0,
        GPRF_CLR  = 1'b1
    } gprf_state_e;

    // One-hot decode of an address into an NREG-wide mask (NREG <= 1024).
    function automatic logic [1023:0] gprf_onehot(input int unsigned idx);
        logic [1023:0] m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage : gprf_pkg

// File: rtl/gprf_scoreboard.sv
// gprf_scoreboard: one pending bit per architectural register.
// A bit is set when an instruction writing that register is issued and
// cleared when the register is written (or swept by a clear). When a set
// and a clear hit the same register in one cycle, the set wins so a newer
// in-flight producer is never forgotten. Register 0 is never pending.
module gprf_scoreboard #(
    parameter  int NREG = 32,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            set_i,       // accepted issue this cycle
    input  logic [AW-1:0]   set_addr_i,  // destination of the accepted issue
    input  logic [NREG-1:0] clr_mask_i,  // registers written or swept this cycle
    output logic [NREG-1:0] pend_o
);

    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;
    logic [NREG-1:0] set_mask;

    // Next pending vector: clear first, then OR in the set so the set wins.
    always_comb begin
        set_mask = '0;
        if (set_i) begin
            set_mask[set_addr_i] = 1'b1;
        end
        pend_d    = (pend_q & ~clr_mask_i) | set_mask;
        pend_d[0] = 1'b0;
    end

    // Pending-bit storage with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend_o = pend_q;

endmodule : gprf_scoreboard

// File: rtl/gprf_mp.sv
// gprf_mp: multi-ported general-purpose register file with an issue
// scoreboard and a sequential clear sweep.
//
// - NWR write ports, NRD combinational read ports; register 0 reads as zero.
// - Same-address writes in one cycle: the highest-index port wins.
// - A clear request walks registers 1..NREG-1, one per cycle, zeroing each
//   register and its pending bit. Writes, issues and further clear requests
//   are dropped while the sweep runs; reads see the partially swept array.
// - Optional macro GPRF_BYPASS_EN: same-cycle write-to-read forwarding of
//   data, and of the pending bit, while the sweep controller is idle.
//
// Issue handshake: an issue transfers on a rising edge where iss_valid and
// iss_ready are both high; iss_valid may be held across cycles and does not
// depend on iss_ready, and iss_ready never depends on iss_valid.
module gprf_mp
    import gprf_pkg::*;
#(
    parameter  int XLEN = GPRF_XLEN_DEF,
    parameter  int NREG = GPRF_NREG_DEF,
    parameter  int NRD  = 2,
    parameter  int NWR  = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NWR-1:0]            we,
    input  logic [NWR-1:0][AW-1:0]    waddr,
    input  logic [NWR-1:0][XLEN-1:0]  wdata,
    input  logic [NRD-1:0][AW-1:0]    raddr,
    output logic [NRD-1:0][XLEN-1:0]  rdata,
    output logic [NRD-1:0]            rd_pend,
    input  logic                      iss_valid,
    input  logic [AW-1:0]             iss_rd,
    output logic                      iss_ready,
    input  logic                      clr_req,
    output logic                      clr_busy,
    output gprf_state_e               dbg_state_o
);

    // ------------------------------------------------------------------
    // Sweep controller state
    // ------------------------------------------------------------------
    gprf_state_e   state_q;
    logic [AW-1:0] cnt_q;
    logic          iss_ready_q;
    logic          clr_busy_q;

    logic          idle;
    logic          iss_acc;
    logic [NREG-1:0] clr_mask;
    logic [NREG-1:0] pend_vec;

    localparam logic [AW-1:0] CNT_FIRST = AW'(1);
    localparam logic [AW-1:0] CNT_LAST  = AW'(NREG - 1);

    assign idle    = (state_q == GPRF_IDLE);
    // iss_ready_q mirrors IDLE, so this is exactly "accepted and not x0".
    assign iss_acc = iss_valid && iss_ready_q && (iss_rd != '0);

    // Sweep FSM: IDLE waits for clr_req, CLR walks cnt from 1 to NREG-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= GPRF_IDLE;
            cnt_q       <= '0;
            iss_ready_q <= 1'b1;
            clr_busy_q  <= 1'b0;
        end else begin
            case (state_q)
                GPRF_IDLE: begin
                    if (clr_req) begin
                        state_q     <= GPRF_CLR;
                        cnt_q       <= CNT_FIRST;
                        iss_ready_q <= 1'b0;
                        clr_busy_q  <= 1'b1;
                    end
                end
                GPRF_CLR: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q     <= GPRF_IDLE;
                        cnt_q       <= '0;
                        iss_ready_q <= 1'b1;
                        clr_busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_FIRST;
                    end
                end
                default: begin
                    state_q     <= GPRF_IDLE;
                    cnt_q       <= '0;
                    iss_ready_q <= 1'b1;
                    clr_busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign iss_ready   = iss_ready_q;
    assign clr_busy    = clr_busy_q;
    assign dbg_state_o = state_q;

    // ------------------------------------------------------------------
    // Register array
    // ------------------------------------------------------------------
    logic [XLEN-1:0] regs_q [NREG];

    // Array update: port-ordered writes in IDLE (later port overrides), one
    // register zeroed per cycle during the sweep; x0 is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
        end else if (idle) begin
            for (int p = 0; p < NWR; p++) begin
                if (we[p] && (waddr[p] != '0)) begin
                    regs_q[waddr[p]] <= wdata[p];
                end
            end
        end else begin
            regs_q[cnt_q] <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------

    // Registers whose pending bit drops at the next edge.
    always_comb begin
        clr_mask = '0;
        if (idle) begin
            for (int p = 0; p < NWR; p++) begin
                if (we[p]) begin
                    clr_mask[waddr[p]] = 1'b1;
                end
            end
        end else begin
            clr_mask[cnt_q] = 1'b1;
        end
    end

    gprf_scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_i      (iss_acc),
        .set_addr_i (iss_rd),
        .clr_mask_i (clr_mask),
        .pend_o     (pend_vec)
    );

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
`ifdef GPRF_BYPASS_EN
    logic [NRD-1:0] fwd_hit;

    // Read path with forwarding: the highest-index matching write supplies
    // data, and a forwarded read is pending only if re-issued this cycle.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            fwd_hit[i] = 1'b0;
            rdata[i]   = (raddr[i] == '0) ? '0 : regs_q[raddr[i]];
            rd_pend[i] = pend_vec[raddr[i]];
            if (idle && (raddr[i] != '0)) begin
                for (int p = 0; p < NWR; p++) begin
                    if (we[p] && (waddr[p] == raddr[i])) begin
                        fwd_hit[i] = 1'b1;
                        rdata[i]   = wdata[p];
                    end
                end
            end
            if (fwd_hit[i]) begin
                rd_pend[i] = iss_acc && (iss_rd == raddr[i]);
            end
        end
    end
`else
    // Read path from registered state only.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rdata[i]   = (raddr[i] == '0) ? '0 : regs_q[raddr[i]];
            rd_pend[i] = pend_vec[raddr[i]];
        end
    end
`endif

endmodule : gprf_mp

// File: tb/tb_gprf_mp.sv
// tb_gprf_mp: randomized and directed bench for gprf_mp with an
// architectural reference model and an expected-response queue.
module tb_gprf_mp;
  import gprf_pkg::*;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int AW   = 5;
  localparam int W    = NRD*XLEN + NRD + 2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic [NWR-1:0]           we;
  logic [NWR-1:0][AW-1:0]   waddr;
  logic [NWR-1:0][XLEN-1:0] wdata;
  logic [NRD-1:0][AW-1:0]   raddr;
  logic [NRD-1:0][XLEN-1:0] rdata;
  logic [NRD-1:0]           rd_pend;
  logic                     iss_valid;
  logic [AW-1:0]            iss_rd;
  logic                     iss_ready;
  logic                     clr_req;
  logic                     clr_busy;
  gprf_state_e              dbg_state;

  gprf_mp #(
    .XLEN (XLEN),
    .NREG (NREG),
    .NRD  (NRD),
    .NWR  (NWR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .we          (we),
    .waddr       (waddr),
    .wdata       (wdata),
    .raddr       (raddr),
    .rdata       (rdata),
    .rd_pend     (rd_pend),
    .iss_valid   (iss_valid),
    .iss_rd      (iss_rd),
    .iss_ready   (iss_ready),
    .clr_req     (clr_req),
    .clr_busy    (clr_busy),
    .dbg_state_o (dbg_state)
  );

  // ---------------- reference model ----------------
  // Architectural view: register values, pending flags, and the index of the
  // next register a running clear will zero (0 means no clear running).
  logic [XLEN-1:0] m_regs [NREG];
  logic            m_pend [NREG];
  int              m_sweep;

  int checks;
  int errors;

  logic [W-1:0] exp_q[$];
  string        name_q[$];

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin
      m_regs[r] = '0;
      m_pend[r] = 1'b0;
    end
    m_sweep = 0;
  endtask

  // Effect of one rising edge on the architectural state.
  task automatic model_edge();
    if (m_sweep != 0) begin
      m_regs[m_sweep] = '0;
      m_pend[m_sweep] = 1'b0;
      m_sweep = (m_sweep == NREG-1) ? 0 : m_sweep + 1;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (we[p]) begin
          if (waddr[p] != 0) m_regs[waddr[p]] = wdata[p];
          m_pend[waddr[p]] = 1'b0;
        end
      end
      if (iss_valid && iss_rd != 0) m_pend[iss_rd] = 1'b1;
      if (clr_req) m_sweep = 1;
    end
  endtask

  // ---------------- driver ----------------
  task automatic idle_inputs();
    we        = '0;
    waddr     = '0;
    wdata     = '0;
    iss_valid = 1'b0;
    iss_rd    = '0;
    clr_req   = 1'b0;
  endtask

  // Called just after a rising edge with inputs already applied: predicts
  // this cycle's outputs, then advances the model across the next edge.
  task automatic step(input string name);
    logic [NRD-1:0][XLEN-1:0] e_rd;
    logic [NRD-1:0]           e_pd;
    int a;
    bit hit;
    if (!rst_n) model_reset();
    for (int i = 0; i < NRD; i++) begin
      a = int'(raddr[i]);
      e_rd[i] = (a == 0) ? '0 : m_regs[a];
      e_pd[i] = (a == 0) ? 1'b0 : m_pend[a];
`ifdef GPRF_BYPASS_EN
      hit = 1'b0;
      if (m_sweep == 0 && a != 0) begin
        for (int p = 0; p < NWR; p++) begin
          if (we[p] && int'(waddr[p]) == a) begin
            hit = 1'b1;
            e_rd[i] = wdata[p];
          end
        end
      end
      if (hit) e_pd[i] = iss_valid && (int'(iss_rd) == a);
`else
      hit = 1'b0;
`endif
    end
    exp_q.push_back({e_rd, e_pd, (m_sweep == 0), (m_sweep != 0)});
    name_q.push_back(name);
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] act;
    string        n;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      n   = name_q.pop_front();
      act = {rdata, rd_pend, iss_ready, clr_busy};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got {rdata,rd_pend,iss_ready,clr_busy}=%h expected %h (raddr=%h)",
                 n, act, e, raddr);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    checks = 0;
    errors = 0;
    model_reset();
    idle_inputs();
    raddr = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    raddr[0] = AW'(5); raddr[1] = AW'(31);
    step("reset_state");
    rst_n = 1'b1;
    step("after_reset");

    // Single write and read-back
    we[0] = 1'b1; waddr[0] = AW'(5); wdata[0] = 32'hDEADBEEF; raddr[0] = AW'(5);
    step("x5_same_cycle");
    idle_inputs();
    step("x5_next_cycle");

    // Port-priority collision and x0 write
    we = 2'b11; waddr[0] = AW'(7); waddr[1] = AW'(7);
    wdata[0] = 32'h11; wdata[1] = 32'h22; raddr[0] = AW'(7); raddr[1] = '0;
    step("x7_collide");
    idle_inputs();
    step("x7_port1_wins");
    we[1] = 1'b1; waddr[1] = '0; wdata[1] = 32'hFFFF_FFFF;
    step("x0_write");
    idle_inputs();
    step("x0_reads_zero");

    // Issue / write-clear priority
    raddr[0] = AW'(3); raddr[1] = '0;
    iss_valid = 1'b1; iss_rd = AW'(3);
    step("iss_x3");
    we[0] = 1'b1; waddr[0] = AW'(3); wdata[0] = 32'h3333;
    step("wr_and_iss_x3");
    idle_inputs();
    step("x3_pend_held");
    we[1] = 1'b1; waddr[1] = AW'(3); wdata[1] = 32'h4444;
    step("wr_x3_alone");
    idle_inputs();
    step("x3_pend_clr");
    iss_valid = 1'b1; iss_rd = '0;
    step("iss_x0");
    idle_inputs();
    step("x0_never_pend");

    // Full load, then clear sweep with traffic that must be ignored
    for (int r = 1; r < NREG; r += 2) begin
      we = 2'b11;
      waddr[0] = AW'(r); wdata[0] = $urandom;
      waddr[1] = AW'((r + 1) % NREG); wdata[1] = $urandom;
      iss_valid = 1'b1; iss_rd = AW'($urandom_range(1, NREG-1));
      raddr[0] = AW'($urandom_range(0, NREG-1)); raddr[1] = AW'(r);
      step("load");
    end
    idle_inputs();
    clr_req = 1'b1;
    step("clr_start");
    for (int c = 0; c < NREG; c++) begin
      we = 2'($urandom_range(0, 3));
      waddr[0] = AW'($urandom_range(0, NREG-1)); wdata[0] = $urandom;
      waddr[1] = AW'($urandom_range(0, NREG-1)); wdata[1] = $urandom;
      iss_valid = 1'($urandom_range(0, 1)); iss_rd = AW'($urandom_range(0, NREG-1));
      clr_req = (c < NREG-2) ? 1'($urandom_range(0, 1)) : 1'b0;
      raddr[0] = AW'($urandom_range(0, NREG-1)); raddr[1] = AW'($urandom_range(0, NREG-1));
      step("sweep");
    end
    idle_inputs();
    for (int r = 0; r < NREG; r += 2) begin
      raddr[0] = AW'(r); raddr[1] = AW'(r + 1);
      step("post_clr");
    end

    // Reset in the middle of a sweep
    for (int r = 1; r < NREG; r += 2) begin
      we = 2'b11;
      waddr[0] = AW'(r); wdata[0] = $urandom;
      waddr[1] = AW'((r + 1) % NREG); wdata[1] = $urandom;
      iss_valid = 1'b1; iss_rd = AW'(NREG - r);
      step("reload");
    end
    idle_inputs();
    clr_req = 1'b1;
    step("clr_start2");
    clr_req = 1'b0;
    for (int c = 1; c < 10; c++) begin
      raddr[0] = AW'(c); raddr[1] = AW'(NREG - c);
      step("sweep2");
    end
    rst_n = 1'b0;
    raddr[0] = AW'(20); raddr[1] = AW'(31);
    step("rst_mid_sweep");
    rst_n = 1'b1;
    step("post_rst");
    for (int r = 0; r < NREG; r += 2) begin
      raddr[0] = AW'(r); raddr[1] = AW'(r + 1);
      step("post_rst_read");
    end

`ifdef GPRF_BYPASS_EN
    // Same-cycle forwarding
    we[0] = 1'b1; waddr[0] = AW'(9); wdata[0] = 32'hA5A5A5A5;
    raddr[0] = '0; raddr[1] = AW'(9);
    step("bypass_x9");
    idle_inputs();
    step("bypass_x9_reg");
`endif

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      we = 2'($urandom_range(0, 3));
      waddr[0] = AW'($urandom_range(0, 7)); wdata[0] = $urandom;
      waddr[1] = AW'($urandom_range(0, 7)); wdata[1] = $urandom;
      iss_valid = 1'($urandom_range(0, 1)); iss_rd = AW'($urandom_range(0, 7));
      clr_req = ($urandom_range(0, 63) == 0);
      raddr[0] = ($urandom_range(0, 1) != 0) ? waddr[0] : AW'($urandom_range(0, 7));
      raddr[1] = ($urandom_range(0, 1) != 0) ? waddr[1] : AW'($urandom_range(0, NREG-1));
      step("random");
    end
    idle_inputs();
    step("final_idle");

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_gprf_mp

// File: doc/gprf_mp.md
GPRF_MP -- requirements
Module: gprf_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32: register width in bits.
REQ-002 SHALL have parameter NREG, default 32: number of registers; power of two, at least 4.
REQ-003 SHALL have parameter NRD, default 2: number of read ports.
REQ-004 SHALL have parameter NWR, default 2: number of write ports.
REQ-005 SHALL derive local AW = $clog2(NREG) as the address width.
REQ-006 clk  in  1  clock; all state updates on the rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 we  in  [NWR]  per-port write enable.
REQ-009 waddr  in  [NWR][AW]  per-port write address.
REQ-010 wdata  in  [NWR][XLEN]  per-port write data.
REQ-011 raddr  in  [NRD][AW]  per-port read address.
REQ-012 rdata  out  [NRD][XLEN]  per-port read data, combinational.
REQ-013 rd_pend  out  [NRD]  scoreboard pending bit of raddr[i], combinational.
REQ-014 iss_valid  in  1  issue request; marks iss_rd pending.
REQ-015 iss_rd  in  [AW]  destination register of the issue.
REQ-016 iss_ready  out  1  issue accepted when high.
REQ-017 clr_req  in  1  request to zero the whole register file.
REQ-018 clr_busy  out  1  high while a clear sweep is in progress.

Function
REQ-019 Register 0 SHALL always read 0, never be written, and never be pending.
REQ-020 Write latency SHALL be 1 cycle: a write at edge N is visible on rdata after edge N.
REQ-021 When several write ports target the same address in one cycle, the highest-index port SHALL win.
REQ-022 Issue SHALL be accepted when iss_valid && iss_ready; pend[iss_rd] SHALL set at the next edge unless iss_rd == 0.
REQ-023 Any accepted write SHALL clear pend[waddr] at the next edge.
REQ-024 If an issue set and a write clear target the same address in one cycle, the set SHALL win.
REQ-025 FSM states SHALL be IDLE and CLR; iss_ready = (state == IDLE); clr_busy = (state == CLR).
REQ-026 In IDLE, clr_req SHALL move the FSM to CLR and load the sweep counter with 1.
REQ-027 In CLR, each cycle SHALL zero register[cnt], clear pend[cnt], and increment cnt; after cnt == NREG-1 is processed, the FSM SHALL return to IDLE (NREG-1 cycles total).
REQ-028 In CLR, we, iss_valid and clr_req SHALL be ignored.
REQ-029 In CLR, reads SHALL return current array contents; registers not yet swept keep their old values.

Reset
REQ-030 On rst_n low, all registers, all pend bits and cnt SHALL go to 0 and the state to IDLE, immediately and independent of clk.
REQ-031 Reset asserted mid-sweep SHALL abort the sweep; after release, the block SHALL be in IDLE with iss_ready=1, clr_busy=0, and all rdata and rd_pend = 0.

Configuration
REQ-032 With macro GPRF_BYPASS_EN defined, the block SHALL apply same-cycle forwarding:
- if raddr[i] != 0 matches an enabled write in IDLE, rdata[i] SHALL equal the winning wdata;
- rd_pend[i] SHALL read 0 unless an issue to the same address is accepted that cycle.
REQ-033 Without GPRF_BYPASS_EN, rdata and rd_pend SHALL reflect only registered state.

Structure
REQ-034 Package gprf_pkg SHALL hold the FSM state enum (GPRF_IDLE, GPRF_CLR) and the default XLEN/NREG constants.
REQ-035 The pending-bit array with its set/clear priority SHALL be a sub-module, gprf_scoreboard.

Verification
REQ-036 The bench SHALL cover the following directed scenarios:
- Write port 0 x5=0xDEADBEEF, read raddr0=5 -> 0xDEADBEEF next cycle; 0 in the same cycle without bypass.
- Ports 0 and 1 both write x7 (0x11, 0x22) -> x7 = 0x22; a write to x0 -> x0 reads 0.
- Issue x3, then write x3 with the same edge holding a new issue to x3 -> rd_pend for x3 stays 1; a write alone then clears it.
- With x1..x31 loaded, pulse clr_req -> clr_busy high 31 cycles, iss_ready 0, all registers 0 afterwards, writes during the sweep discarded.
- Assert rst_n low at sweep cycle 10 -> immediate IDLE, all registers and pend 0.
- With GPRF_BYPASS_EN: write x9=0xA5A5A5A5 while raddr1=9 -> rdata1=0xA5A5A5A5 in the same cycle.
